jk_excite_drv: RTL
==================

# jk_excite_drv

Excitation driver for a bank of WIDTH JK flip-flops sharing clk/reset. It accepts target state words over a valid/ready stream and buffers them in a small FIFO. For each word it issues one j/k/valid command that moves the flop bank from its current state to the target. It then checks the bank's q feedback against the expected state and latches sticky mismatch flags.

## Interface
- WIDTH, 4, number of JK flops driven
- DEPTH, 4, FIFO entries (power of two, ≥2)
- clk  input  1  clock
- reset  input  1  asynchronous, active-high
- in_valid  input  1  target word offered
- in_ready  output  1  FIFO not full
- in_data  input  WIDTH  target q state
- mode  input  1  excitation encoding, sampled at pop: 0 = DIRECT, 1 = TOGGLE
- hold  input  1  downstream pause; no pop while high
- j  output  WIDTH  J inputs to flop bank (registered)
- k  output  WIDTH  K inputs to flop bank (registered)
- out_valid  output  1  command valid to flop bank (registered)
- q_fb  input  WIDTH  q outputs of flop bank
- clear_err  input  1  synchronous clear of error flags
- mismatch  output  1  sticky: any bit compare failed
- err_bits  output  WIDTH  sticky per-bit compare failure
- level  output  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Reset values: j=0, k=0, out_valid=0, mismatch=0, err_bits=0, level=0, in_ready=1.
- Reset clears the shadow register S (state the bank holds after reset) to 0, empties the FIFO and clears the compare pipeline.
- Push: in_valid & in_ready at an edge writes in_data. in_ready = (level != DEPTH). Push while full is impossible by construction.
- Pop: FIFO non-empty & !hold at an edge pops head T. The same edge registers the excitation, sets out_valid=1 and sets S<=T.
- Excitation per bit i, from S[i] (pre-pop) and T[i]:
  - S==T → j=0, k=0.
  - DIRECT, 0→1 → j=1, k=0.
  - DIRECT, 1→0 → j=0, k=1.
  - TOGGLE, any change → j=1, k=1.
- A word equal to S is still issued, as out_valid=1 with j=k=0.
- No pop at an edge → out_valid=0, j=0, k=0.
- Simultaneous push and pop allowed when 0<level<DEPTH; level is unchanged.
- Pointers wrap modulo DEPTH.
- Compare: the expected value E=T travels with the command. Two edges after the pop edge, q_fb is compared with E. Any differing bit sets err_bits[i] and mismatch.
- clear_err zeroes err_bits and mismatch. A set at the same edge wins.
- Reset mid-operation discards queued and in-flight words. No compare fires for commands issued before reset.

## Timing
- Edge A: push. Earliest pop is edge A+1, where j/k/out_valid are registered; there is no FIFO bypass.
- Edge A+2: the flop bank captures the command, and q_fb reflects it afterwards.
- Edge A+3: compare registered, and mismatch is visible after it.
- Throughput: one word per cycle while !hold and non-empty.
- hold high: pops stop on the same edge. out_valid is 0 from the next edge, and the FIFO retains its contents.
- Compare pipeline: two valid-tagged stages (E1, E2), each carrying E. It never stalls.

## Structure
- Package jk_drv_pkg holds:
  - mode constants MODE_DIRECT=1'b0 and MODE_TOGGLE=1'b1;
  - function jk_excite(s, t, mode) returning {j,k} for one bit.
- Sub-module jk_drv_fifo: synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/level, async reset.
- Top level contains the shadow register, output registers and compare pipeline.

## Test plan
All scenarios use WIDTH=4, DEPTH=4, with a behavioural JK bank attached.
- Reset, then push 4'b1010 with mode=0 → one cycle of out_valid=1, j=4'b1010, k=4'b0000. q_fb=4'b1010 two edges later; mismatch=0.
- Then push 4'b0110 with mode=1 → j=4'b1100, k=4'b1100; q_fb=4'b0110.
- With hold=1, push 4 words → in_ready=0, level=4, out_valid stays 0. Release hold → 4 consecutive out_valid cycles in order, then level=0 and in_ready=1.
- Force bit 2 of q_fb stuck at 0 and push 4'b0100 → err_bits=4'b0100 and mismatch=1, staying set. Pulse clear_err with no new fault → both return to 0.
- Push the same word as the current state → out_valid=1, j=k=0, no error.
- Assert reset while 3 words are queued → level=0, out_valid=0, err flags=0 immediately. Push 4'b0001 after release → j=4'b0001, proving S=0.

Source files
------------

// File: rtl/jk_drv_pkg.sv
// Shared mode encodings and the per-bit JK excitation rule for the excitation driver.
package jk_drv_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_TOGGLE = 1'b1;

  // Returns {j,k} that moves one JK flop from s to t.
  function automatic logic [1:0] jk_excite(input logic s, input logic t, input logic mode);
    logic [1:0] w_jk;
    if (s == t)
      w_jk = 2'b00;
    else if (mode == MODE_TOGGLE)
      w_jk = 2'b11;
    else if (t)
      w_jk = 2'b10;
    else
      w_jk = 2'b01;
    return w_jk;
  endfunction

endpackage

// File: rtl/jk_excite_drv_if.sv
// Valid/ready stream carrying target state words into the excitation driver.
interface jk_excite_drv_if #(
  parameter int WIDTH = 4
) ();
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/jk_drv_fifo.sv
// Synchronous FIFO holding pending target words; pointers wrap naturally (DEPTH power of two).
module jk_drv_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

endmodule

// File: rtl/jk_excite_drv.sv
// JK bank excitation driver: pops target words, issues registered j/k commands,
// and checks the bank's q feedback two edges later with sticky error flags.
module jk_excite_drv
  import jk_drv_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  jk_excite_drv_if.slave         s_in,
  input  logic                   i_mode,
  input  logic                   i_hold,
  output logic [WIDTH-1:0]       o_j,
  output logic [WIDTH-1:0]       o_k,
  output logic                   o_out_valid,
  input  logic [WIDTH-1:0]       i_q_fb,
  input  logic                   i_clear_err,
  output logic                   o_mismatch,
  output logic [WIDTH-1:0]       o_err_bits,
  output logic [$clog2(DEPTH):0] o_level
);

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_head;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_diff;

  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_j;
  logic [WIDTH-1:0] r_k;
  logic             r_out_valid;
  logic             r_e1_v;
  logic [WIDTH-1:0] r_e1;
  logic             r_e2_v;
  logic [WIDTH-1:0] r_e2;
  logic [WIDTH-1:0] r_err_bits;
  logic             r_mismatch;

  assign s_in.ready = ~w_full;
  assign w_push     = s_in.valid & ~w_full;
  assign w_pop      = ~w_empty & ~i_hold;

  jk_drv_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata (s_in.data),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_level)
  );

  always_comb begin
    w_j = '0;
    w_k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {w_j[i], w_k[i]} = jk_excite(r_shadow[i], w_head[i], i_mode);
    end
  end

  // Stage E2 lines up with the cycle after the bank has captured the command.
  assign w_diff = r_e2_v ? (i_q_fb ^ r_e2) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow    <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_out_valid <= 1'b0;
      r_e1_v      <= 1'b0;
      r_e1        <= '0;
      r_e2_v      <= 1'b0;
      r_e2        <= '0;
      r_err_bits  <= '0;
      r_mismatch  <= 1'b0;
    end else begin
      r_out_valid <= w_pop;
      r_j         <= w_pop ? w_j : '0;
      r_k         <= w_pop ? w_k : '0;
      if (w_pop) r_shadow <= w_head;
      r_e1_v      <= w_pop;
      r_e1        <= w_head;
      r_e2_v      <= r_e1_v;
      r_e2        <= r_e1;
      // A new failure at the same edge as clear_err survives the clear.
      r_err_bits  <= (i_clear_err ? '0 : r_err_bits) | w_diff;
      r_mismatch  <= (i_clear_err ? 1'b0 : r_mismatch) | (|w_diff);
    end
  end

  assign o_j         = r_j;
  assign o_k         = r_k;
  assign o_out_valid = r_out_valid;
  assign o_err_bits  = r_err_bits;
  assign o_mismatch  = r_mismatch;

endmodule
